spi_flash_arbiter: RTL and testbench

//  Shares the single SPI configuration-flash bus between two masters: port 0 (DFU core,

---
 rtl/spi_flash_arbiter.sv | 151 +++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// Two-master arbiter for a shared SPI configuration flash: req/gnt handshake,
// pin muxing, a chip-select-high gap between owners and an optional hold timeout.
module spi_flash_arbiter #(
  parameter int GAP_CYCLES  = 4,
  parameter int HOLD_MAX    = 0,
  parameter int ROUND_ROBIN = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic m0_req_i,
  output logic m0_gnt_o,
  input  logic m0_csel_i,
  input  logic m0_sck_i,
  input  logic m0_mosi_i,
  output logic m0_miso_o,
  input  logic m1_req_i,
  output logic m1_gnt_o,
  input  logic m1_csel_i,
  input  logic m1_sck_i,
  input  logic m1_mosi_i,
  output logic m1_miso_o,
  output logic spi_csel_o,
  output logic spi_clk_o,
  output logic spi_mosi_o,
  input  logic spi_miso_i,
  output logic owner_o,
  output logic timeout_o
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int GapLastInt  = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
  localparam int HoldLastInt = (HOLD_MAX > 1) ? HOLD_MAX - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GapLastInt);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HoldLastInt);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          owner_q, owner_d;
  logic          timeout_q, timeout_d;
  logic          mask0_q, mask0_d;
  logic          mask1_q, mask1_d;
  logic          elig0, elig1, sel, own_req;

  assign elig0 = m0_req_i & ~mask0_q;
  assign elig1 = m1_req_i & ~mask1_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    // A revoked port stays masked until it has dropped its request.
    mask0_d   = mask0_q & m0_req_i;
    mask1_d   = mask1_q & m1_req_i;
    sel       = 1'b0;
    own_req   = (state_q == OWN1) ? m1_req_i : m0_req_i;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        gap_d  = '0;
        if (elig0 || elig1) begin
          if (elig0 && elig1) sel = (ROUND_ROBIN != 0) ? ~owner_q : 1'b0;
          else                sel = elig1;
          state_d = sel ? OWN1 : OWN0;
          owner_d = sel;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_d = GAP;
          gap_d   = '0;
        end else if ((HOLD_MAX != 0) && (hold_q == HOLD_LAST)) begin
          state_d   = GAP;
          gap_d     = '0;
          timeout_d = 1'b1;
          if (state_q == OWN1) mask1_d = 1'b1;
          else                 mask0_d = 1'b1;
        end else if (HOLD_MAX != 0) begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      hold_q    <= '0;
      owner_q   <= 1'b0;
      timeout_q <= 1'b0;
      mask0_q   <= 1'b0;
      mask1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      mask0_q   <= mask0_d;
      mask1_q   <= mask1_d;
    end
  end

  // Pins are a pure mux on the registered state, so reset idles them immediately.
  always_comb begin
    spi_csel_o = 1'b1;
    spi_clk_o  = 1'b0;
    spi_mosi_o = 1'b0;
    m0_miso_o  = 1'b0;
    m1_miso_o  = 1'b0;
    case (state_q)
      OWN0: begin
        spi_csel_o = m0_csel_i;
        spi_clk_o  = m0_sck_i;
        spi_mosi_o = m0_mosi_i;
        m0_miso_o  = spi_miso_i;
      end
      OWN1: begin
        spi_csel_o = m1_csel_i;
        spi_clk_o  = m1_sck_i;
        spi_mosi_o = m1_mosi_i;
        m1_miso_o  = spi_miso_i;
      end
      default: ;
    endcase
  end

  assign m0_gnt_o  = (state_q == OWN0);
  assign m1_gnt_o  = (state_q == OWN1);
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: instance A uses the default parameters,
// instance B uses fixed priority with a 16-cycle hold limit.
module tb_spi_flash_arbiter;

  logic clk;
  logic rstN;
  int checks;
  int passes;

  logic aM0Req, aM0Gnt, aM0Csel, aM0Sck, aM0Mosi, aM0Miso;
  logic aM1Req, aM1Gnt, aM1Csel, aM1Sck, aM1Mosi, aM1Miso;
  logic aSpiCsel, aSpiClk, aSpiMosi, aSpiMiso, aOwner, aTimeout;
  logic bM0Req, bM0Gnt, bM0Csel, bM0Sck, bM0Mosi, bM0Miso;
  logic bM1Req, bM1Gnt, bM1Csel, bM1Sck, bM1Mosi, bM1Miso;
  logic bSpiCsel, bSpiClk, bSpiMosi, bSpiMiso, bOwner, bTimeout;

  spi_flash_arbiter #(.GAP_CYCLES(4), .HOLD_MAX(0), .ROUND_ROBIN(1)) dutA (
    .clk_i(clk), .rst_ni(rstN),
    .m0_req_i(aM0Req), .m0_gnt_o(aM0Gnt), .m0_csel_i(aM0Csel), .m0_sck_i(aM0Sck),
    .m0_mosi_i(aM0Mosi), .m0_miso_o(aM0Miso),
    .m1_req_i(aM1Req), .m1_gnt_o(aM1Gnt), .m1_csel_i(aM1Csel), .m1_sck_i(aM1Sck),
    .m1_mosi_i(aM1Mosi), .m1_miso_o(aM1Miso),
    .spi_csel_o(aSpiCsel), .spi_clk_o(aSpiClk), .spi_mosi_o(aSpiMosi),
    .spi_miso_i(aSpiMiso), .owner_o(aOwner), .timeout_o(aTimeout)
  );

  spi_flash_arbiter #(.GAP_CYCLES(4), .HOLD_MAX(16), .ROUND_ROBIN(0)) dutB (
    .clk_i(clk), .rst_ni(rstN),
    .m0_req_i(bM0Req), .m0_gnt_o(bM0Gnt), .m0_csel_i(bM0Csel), .m0_sck_i(bM0Sck),
    .m0_mosi_i(bM0Mosi), .m0_miso_o(bM0Miso),
    .m1_req_i(bM1Req), .m1_gnt_o(bM1Gnt), .m1_csel_i(bM1Csel), .m1_sck_i(bM1Sck),
    .m1_mosi_i(bM1Mosi), .m1_miso_o(bM1Miso),
    .spi_csel_o(bSpiCsel), .spi_clk_o(bSpiClk), .spi_mosi_o(bSpiMosi),
    .spi_miso_i(bSpiMiso), .owner_o(bOwner), .timeout_o(bTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then step 1 time unit off the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aM0Req = 0; aM0Csel = 1; aM0Sck = 0; aM0Mosi = 0;
    aM1Req = 0; aM1Csel = 1; aM1Sck = 0; aM1Mosi = 0; aSpiMiso = 0;
    bM0Req = 0; bM0Csel = 1; bM0Sck = 0; bM0Mosi = 0;
    bM1Req = 0; bM1Csel = 1; bM1Sck = 0; bM1Mosi = 0; bSpiMiso = 0;
    rstN = 0;
    #7;
    checks++; if (aM0Gnt !== 1'b0) $display("[TB] FAIL reset_m0_gnt: got %b expected 0", aM0Gnt); else passes++;
    checks++; if (aM1Gnt !== 1'b0) $display("[TB] FAIL reset_m1_gnt: got %b expected 0", aM1Gnt); else passes++;
    checks++; if (aSpiCsel !== 1'b1) $display("[TB] FAIL reset_csel: got %b expected 1", aSpiCsel); else passes++;
    checks++; if (aSpiClk !== 1'b0) $display("[TB] FAIL reset_clk: got %b expected 0", aSpiClk); else passes++;
    checks++; if (aOwner !== 1'b0) $display("[TB] FAIL reset_owner: got %b expected 0", aOwner); else passes++;
    checks++; if (aTimeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b expected 0", aTimeout); else passes++;
    checks++; if (bSpiCsel !== 1'b1) $display("[TB] FAIL reset_b_csel: got %b expected 1", bSpiCsel); else passes++;
    @(negedge clk);
    rstN = 1;
    cyc(1);
  endtask

  task automatic test_single_owner();
    aM0Req = 1; aM0Csel = 1;
    cyc(1);
    checks++; if (aM0Gnt !== 1'b1) $display("[TB] FAIL single_gnt: got %b expected 1", aM0Gnt); else passes++;
    checks++; if (aOwner !== 1'b0) $display("[TB] FAIL single_owner: got %b expected 0", aOwner); else passes++;
    aM0Csel = 0; aM0Sck = 1; aM0Mosi = 1; aSpiMiso = 1; aM1Csel = 0;
    #1;
    checks++; if (aSpiCsel !== 1'b0) $display("[TB] FAIL single_csel: got %b expected 0", aSpiCsel); else passes++;
    checks++; if (aSpiClk !== 1'b1) $display("[TB] FAIL single_clk: got %b expected 1", aSpiClk); else passes++;
    checks++; if (aSpiMosi !== 1'b1) $display("[TB] FAIL single_mosi: got %b expected 1", aSpiMosi); else passes++;
    checks++; if (aM0Miso !== 1'b1) $display("[TB] FAIL single_m0_miso: got %b expected 1", aM0Miso); else passes++;
    checks++; if (aM1Miso !== 1'b0) $display("[TB] FAIL single_m1_miso: got %b expected 0", aM1Miso); else passes++;
    aM0Sck = 0;
    #1;
    checks++; if (aSpiClk !== 1'b0) $display("[TB] FAIL single_clk_follow: got %b expected 0", aSpiClk); else passes++;
    aM0Csel = 1; aM1Csel = 1; aM0Req = 0;
    cyc(1);
    checks++; if (aM0Gnt !== 1'b0) $display("[TB] FAIL release_gnt: got %b expected 0", aM0Gnt); else passes++;
    checks++; if (aSpiCsel !== 1'b1) $display("[TB] FAIL release_csel: got %b expected 1", aSpiCsel); else passes++;
    aM0Csel = 0; aM0Req = 1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      checks++; if (aM0Gnt !== 1'b0) $display("[TB] FAIL gap_gnt_%0d: got %b expected 0", k, aM0Gnt); else passes++;
      checks++; if (aSpiCsel !== 1'b1) $display("[TB] FAIL gap_csel_%0d: got %b expected 1", k, aSpiCsel); else passes++;
    end
    cyc(1);
    checks++; if (aM0Gnt !== 1'b1) $display("[TB] FAIL regrant_gnt: got %b expected 1", aM0Gnt); else passes++;
    aM0Csel = 1; aM0Req = 0; aSpiMiso = 0; aM0Mosi = 0;
    cyc(6);
  endtask

  task automatic test_round_robin();
    aM0Req = 1; aM1Req = 1;
    cyc(1);
    checks++; if (aM1Gnt !== 1'b1) $display("[TB] FAIL rr_m1_gnt: got %b expected 1", aM1Gnt); else passes++;
    checks++; if (aM0Gnt !== 1'b0) $display("[TB] FAIL rr_m0_gnt: got %b expected 0", aM0Gnt); else passes++;
    checks++; if (aOwner !== 1'b1) $display("[TB] FAIL rr_owner1: got %b expected 1", aOwner); else passes++;
    aM1Req = 0;
    cyc(1);
    checks++; if (aM1Gnt !== 1'b0) $display("[TB] FAIL rr_m1_release: got %b expected 0", aM1Gnt); else passes++;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      checks++; if (aM0Gnt !== 1'b0) $display("[TB] FAIL rr_wait_%0d: got %b expected 0", k, aM0Gnt); else passes++;
    end
    cyc(1);
    checks++; if (aM0Gnt !== 1'b1) $display("[TB] FAIL rr_m0_after_gap: got %b expected 1", aM0Gnt); else passes++;
    checks++; if (aOwner !== 1'b0) $display("[TB] FAIL rr_owner0: got %b expected 0", aOwner); else passes++;
    aM0Req = 0;
    cyc(6);
  endtask

  task automatic test_gap_pulse();
    aM0Req = 1;
    cyc(1);
    aM0Req = 0;
    cyc(1);
    aM1Req = 1;
    cyc(1);
    aM1Req = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      checks++; if (aM1Gnt !== 1'b0) $display("[TB] FAIL pulse_no_gnt_%0d: got %b expected 0", k, aM1Gnt); else passes++;
    end
    aM1Req = 1;
    cyc(1);
    checks++; if (aM1Gnt !== 1'b1) $display("[TB] FAIL pulse_idle_gnt: got %b expected 1", aM1Gnt); else passes++;
    aM1Req = 0;
    cyc(6);
  endtask

  task automatic test_async_reset();
    aM0Req = 1;
    cyc(1);
    aM0Csel = 0; aM0Sck = 1; aM0Mosi = 1;
    #1;
    checks++; if (aSpiCsel !== 1'b0) $display("[TB] FAIL ar_pre_csel: got %b expected 0", aSpiCsel); else passes++;
    #2 rstN = 0;
    #1;
    checks++; if (aSpiCsel !== 1'b1) $display("[TB] FAIL ar_csel: got %b expected 1", aSpiCsel); else passes++;
    checks++; if (aSpiClk !== 1'b0) $display("[TB] FAIL ar_clk: got %b expected 0", aSpiClk); else passes++;
    checks++; if (aSpiMosi !== 1'b0) $display("[TB] FAIL ar_mosi: got %b expected 0", aSpiMosi); else passes++;
    checks++; if (aM0Gnt !== 1'b0) $display("[TB] FAIL ar_gnt: got %b expected 0", aM0Gnt); else passes++;
    aM0Csel = 1; aM0Sck = 0; aM0Mosi = 0;
    #1 rstN = 1;
    #1;
    checks++; if (aM0Gnt !== 1'b0) $display("[TB] FAIL ar_gnt_released: got %b expected 0", aM0Gnt); else passes++;
    cyc(1);
    checks++; if (aM0Gnt !== 1'b1) $display("[TB] FAIL ar_regrant: got %b expected 1", aM0Gnt); else passes++;
    aM0Req = 0;
    cyc(6);
  endtask

  task automatic test_fixed_priority();
    for (int r = 0; r < 3; r++) begin
      bM0Req = 1; bM1Req = 1;
      cyc(1);
      checks++; if (bM0Gnt !== 1'b1) $display("[TB] FAIL fp_m0_gnt_%0d: got %b expected 1", r, bM0Gnt); else passes++;
      checks++; if (bM1Gnt !== 1'b0) $display("[TB] FAIL fp_m1_gnt_%0d: got %b expected 0", r, bM1Gnt); else passes++;
      bM0Req = 0; bM1Req = 0;
      cyc(6);
    end
    bM0Req = 1; bM1Req = 1;
    cyc(1);
    checks++; if (bM0Gnt !== 1'b1) $display("[TB] FAIL fp_last_m0: got %b expected 1", bM0Gnt); else passes++;
    bM0Req = 0;
    cyc(6);
    checks++; if (bM1Gnt !== 1'b1) $display("[TB] FAIL fp_m1_after: got %b expected 1", bM1Gnt); else passes++;
    checks++; if (bOwner !== 1'b1) $display("[TB] FAIL fp_owner: got %b expected 1", bOwner); else passes++;
    bM1Req = 0;
    cyc(6);
  endtask

  task automatic test_timeout();
    int pulses;
    bM1Req = 1;
    cyc(1);
    bM1Csel = 0;
    for (int k = 1; k <= 16; k++) begin
      checks++; if (bM1Gnt !== 1'b1) $display("[TB] FAIL to_gnt_cycle_%0d: got %b expected 1", k, bM1Gnt); else passes++;
      checks++; if (bTimeout !== 1'b0) $display("[TB] FAIL to_early_%0d: got %b expected 0", k, bTimeout); else passes++;
      cyc(1);
    end
    checks++; if (bM1Gnt !== 1'b0) $display("[TB] FAIL to_revoked: got %b expected 0", bM1Gnt); else passes++;
    checks++; if (bTimeout !== 1'b1) $display("[TB] FAIL to_pulse: got %b expected 1", bTimeout); else passes++;
    checks++; if (bSpiCsel !== 1'b1) $display("[TB] FAIL to_csel: got %b expected 1", bSpiCsel); else passes++;
    pulses = 1;
    for (int k = 0; k < 22; k++) begin
      cyc(1);
      if (bTimeout === 1'b1) pulses++;
      checks++; if (bM1Gnt !== 1'b0) $display("[TB] FAIL to_masked_%0d: got %b expected 0", k, bM1Gnt); else passes++;
    end
    checks++; if (pulses !== 1) $display("[TB] FAIL to_pulse_count: got %0d expected 1", pulses); else passes++;
    bM1Req = 0; bM1Csel = 1;
    cyc(1);
    bM1Req = 1;
    cyc(1);
    checks++; if (bM1Gnt !== 1'b1) $display("[TB] FAIL to_regrant: got %b expected 1", bM1Gnt); else passes++;
    bM1Req = 0;
    cyc(6);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_gap_pulse();
    test_async_reset();
    test_fixed_priority();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
